// File: rtl/bcd_countdown.sv
// bcd_countdown: multi-digit BCD countdown timer.
//
// Counts down one BCD step per `tick` strobe from the upstream divider while
// running. The timer also drives that divider's count-enable (`tick_en`), so
// the divider only advances while the timer is in RUN.
//
// Ports:
//   clk       system clock
//   rst       asynchronous, active-high reset
//   tick      one-cycle advance strobe from the upstream divider
//   load      level; loads the preset in IDLE, PAUSE or DONE
//   load_val  BCD preset, digit 0 = bits [3:0]; digits > 9 are clamped to 9
//   start     level; its rising edge starts or resumes the count
//   pause     level; its rising edge pauses RUN, or resumes from PAUSE
//   count     current BCD count
//   tick_en   enable to the upstream divider; high only in RUN
//   running   high in RUN
//   done      one-cycle pulse, coincident with count reaching zero
//   expired   high in DONE
module bcd_countdown #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  output logic [4*DIGITS-1:0] count,
  output logic                tick_en,
  output logic                running,
  output logic                done,
  output logic                expired
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   count_next;
  logic [W-1:0]   reload, reload_next;
  logic           done_next;
  logic           start_prev, pause_prev;
  logic           start_rise, pause_rise;
  logic [W-1:0]   count_dec;
  logic [W-1:0]   load_clean;

  // Clamp every digit above 9 down to 9 so count always holds valid BCD.
  function automatic logic [W-1:0] sanitise(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // BCD decrement by one: a digit at 0 with an incoming borrow becomes 9
  // and passes the borrow on to the next digit.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign start_rise = start & ~start_prev;
  assign pause_rise = pause & ~pause_prev;
  assign count_dec  = bcd_dec(count);
  assign load_clean = sanitise(load_val);

  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          count_next  = load_clean;
          reload_next = load_clean;
        end else if (start_rise && (count != '0)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // A tick in the same cycle as a pause edge is applied first; reaching
        // zero takes the timer to DONE rather than PAUSE.
        if (tick) begin
          count_next = count_dec;
          if (count_dec == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else if (pause_rise) begin
            state_next = PAUSE;
          end
        end else if (pause_rise) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (load) begin
          count_next  = load_clean;
          reload_next = load_clean;
          state_next  = IDLE;
        end else if (start_rise || pause_rise) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (load) begin
          count_next  = load_clean;
          reload_next = load_clean;
          state_next  = IDLE;
        end else if (start_rise && (reload != '0)) begin
          count_next = reload;
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Edge history resets to 1 so a button held through reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload     <= '0;
      done       <= 1'b0;
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
    end else begin
      state      <= state_next;
      count      <= count_next;
      reload     <= reload_next;
      done       <= done_next;
      start_prev <= start;
      pause_prev <= pause;
    end
  end

  assign tick_en = (state == RUN);
  assign running = (state == RUN);
  assign expired = (state == DONE);

endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: directed self-checking bench for bcd_countdown (DIGITS=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bcd_countdown;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] count;
  logic        tick_en;
  logic        running;
  logic        done;
  logic        expired;

  int checks = 0;
  int fails  = 0;

  logic [15:0] seq12 [12] = '{16'h0011, 16'h0010, 16'h0009, 16'h0008,
                              16'h0007, 16'h0006, 16'h0005, 16'h0004,
                              16'h0003, 16'h0002, 16'h0001, 16'h0000};

  bcd_countdown #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .count    (count),
    .tick_en  (tick_en),
    .running  (running),
    .done     (done),
    .expired  (expired)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (count !== 16'h0000 || done !== 1'b0 || expired !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: count=%h done=%b expired=%b want 0000/0/0", count, done, expired);
    end
    checks++;
    if (running !== 1'b0 || tick_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_run: running=%b tick_en=%b want 0/0", running, tick_en);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 16'h0000 || running !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: count=%h running=%b want 0000/0", count, running);
    end
  endtask

  task automatic test_countdown();
    do_load(16'h0012);
    checks++;
    if (count !== 16'h0012 || running !== 1'b0) begin
      fails++;
      $display("FAIL cd_load: count=%h running=%b want 0012/0", count, running);
    end
    pulse_start();
    checks++;
    if (running !== 1'b1 || tick_en !== 1'b1) begin
      fails++;
      $display("FAIL cd_start: running=%b tick_en=%b want 1/1", running, tick_en);
    end
    for (int i = 0; i < 12; i++) begin
      do_tick();
      checks++;
      if (count !== seq12[i]) begin
        fails++;
        $display("FAIL cd_step%0d: count=%h want %h", i, count, seq12[i]);
      end
      if (i < 11) begin
        checks++;
        if (done !== 1'b0 || running !== 1'b1) begin
          fails++;
          $display("FAIL cd_mid%0d: done=%b running=%b want 0/1", i, done, running);
        end
      end else begin
        checks++;
        if (done !== 1'b1 || expired !== 1'b1 || tick_en !== 1'b0) begin
          fails++;
          $display("FAIL cd_expire: done=%b expired=%b tick_en=%b want 1/1/0", done, expired, tick_en);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || expired !== 1'b1 || count !== 16'h0000) begin
          fails++;
          $display("FAIL cd_after: done=%b expired=%b count=%h want 0/1/0000", done, expired, count);
        end
      end
      repeat (4) @(negedge clk);
    end
    checks++;
    if (done !== 1'b0 || expired !== 1'b1 || tick_en !== 1'b0) begin
      fails++;
      $display("FAIL cd_settle: done=%b expired=%b tick_en=%b want 0/1/0", done, expired, tick_en);
    end
  endtask

  task automatic test_borrow();
    do_load(16'h1000);
    checks++;
    if (count !== 16'h1000 || expired !== 1'b0) begin
      fails++;
      $display("FAIL br_load: count=%h expired=%b want 1000/0", count, expired);
    end
    pulse_start();
    do_tick();
    checks++;
    if (count !== 16'h0999) begin
      fails++;
      $display("FAIL br_count: count=%h want 0999", count);
    end
    checks++;
    if (running !== 1'b1 || tick_en !== 1'b1) begin
      fails++;
      $display("FAIL br_run: running=%b tick_en=%b want 1/1", running, tick_en);
    end
  endtask

  task automatic test_pause();
    do_load(16'h0030);
    pulse_start();
    do_tick();
    @(negedge clk);
    do_tick();
    checks++;
    if (count !== 16'h0028) begin
      fails++;
      $display("FAIL ps_pre: count=%h want 0028", count);
    end
    pulse_pause();
    checks++;
    if (running !== 1'b0 || tick_en !== 1'b0 || expired !== 1'b0) begin
      fails++;
      $display("FAIL ps_state: running=%b tick_en=%b expired=%b want 0/0/0", running, tick_en, expired);
    end
    for (int i = 0; i < 4; i++) begin
      do_tick();
      checks++;
      if (count !== 16'h0028 || tick_en !== 1'b0) begin
        fails++;
        $display("FAIL ps_hold%0d: count=%h tick_en=%b want 0028/0", i, count, tick_en);
      end
    end
    pulse_start();
    checks++;
    if (running !== 1'b1) begin
      fails++;
      $display("FAIL ps_resume: running=%b want 1", running);
    end
    do_tick();
    checks++;
    if (count !== 16'h0027) begin
      fails++;
      $display("FAIL ps_next: count=%h want 0027", count);
    end
  endtask

  task automatic test_tick_pause_same();
    do_load(16'h0001);
    pulse_start();
    tick = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    pause = 1'b0;
    checks++;
    if (count !== 16'h0000 || expired !== 1'b1 || done !== 1'b1 || running !== 1'b0) begin
      fails++;
      $display("FAIL tp_done: count=%h expired=%b done=%b running=%b want 0000/1/1/0",
               count, expired, done, running);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || expired !== 1'b1) begin
      fails++;
      $display("FAIL tp_after: done=%b expired=%b want 0/1", done, expired);
    end
  endtask

  task automatic test_sanitise_held_start();
    start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_load(16'hFA3C);
    checks++;
    if (count !== 16'h9939) begin
      fails++;
      $display("FAIL sn_clamp: count=%h want 9939", count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (running !== 1'b0) begin
      fails++;
      $display("FAIL sn_held: running=%b want 0", running);
    end
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (running !== 1'b1) begin
      fails++;
      $display("FAIL sn_fresh: running=%b want 1", running);
    end
    start = 1'b0;
    @(negedge clk);
    do_tick();
    checks++;
    if (count !== 16'h9938) begin
      fails++;
      $display("FAIL sn_tick: count=%h want 9938", count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 16'h0000 || running !== 1'b0 || tick_en !== 1'b0) begin
      fails++;
      $display("FAIL sn_async: count=%h running=%b tick_en=%b want 0000/0/0", count, running, tick_en);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reload_done();
    do_load(16'h0005);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      do_tick();
      @(negedge clk);
    end
    checks++;
    if (expired !== 1'b1 || count !== 16'h0000) begin
      fails++;
      $display("FAIL rl_exp1: expired=%b count=%h want 1/0000", expired, count);
    end
    pulse_start();
    checks++;
    if (count !== 16'h0005 || running !== 1'b1) begin
      fails++;
      $display("FAIL rl_restart: count=%h running=%b want 0005/1", count, running);
    end
    for (int i = 0; i < 5; i++) begin
      do_tick();
      @(negedge clk);
    end
    checks++;
    if (expired !== 1'b1) begin
      fails++;
      $display("FAIL rl_exp2: expired=%b want 1", expired);
    end
    load_val = 16'h0002;
    load = 1'b1;
    start = 1'b1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    checks++;
    if (count !== 16'h0002 || running !== 1'b0 || expired !== 1'b0) begin
      fails++;
      $display("FAIL rl_loadwin: count=%h running=%b expired=%b want 0002/0/0", count, running, expired);
    end
    @(negedge clk);
    checks++;
    if (running !== 1'b0 || count !== 16'h0002) begin
      fails++;
      $display("FAIL rl_idle: running=%b count=%h want 0/0002", running, count);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    apply_reset();
    test_pause();
    apply_reset();
    test_tick_pause_same();
    apply_reset();
    test_sanitise_held_start();
    test_reload_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
